// File: rtl/pipe_hazard_ctrl.sv
// Pipeline control for the 16-bit 5-stage core: load-use, taken-branch and
// data-memory stall handling, processor halt and memory-timeout error.
module pipe_hazard_ctrl #(
    parameter int unsigned WAIT_MAX = 15,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             memread_ex,
    input  logic             regwrite_ex,
    input  logic [2:0]       regwrite_adr_ex,
    input  logic [2:0]       rs_adr_id,
    input  logic [2:0]       rt_adr_id,
    input  logic             use_rs_id,
    input  logic             use_rt_id,
    input  logic             branch_taken_ex,
    input  logic             mem_req,
    input  logic             mem_ready,
    input  logic             halt_wb,
    output logic             en_pc,
    output logic             en_ifid,
    output logic             en_idex,
    output logic             en_exmem,
    output logic             en_memwb,
    output logic             flush_ifid,
    output logic             flush_idex,
    output logic             flush_exmem,
    output logic             flush_memwb,
    output logic             halted,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam int unsigned     WCNT_W     = 8;
    localparam logic [WCNT_W-1:0] WAIT_LIMIT = WCNT_W'(WAIT_MAX);
    localparam logic [CNT_W-1:0]  CNT_MAX    = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_MEMWAIT = 2'd1,
        ST_HALT    = 2'd2
    } state_t;

    state_t              state;
    logic [WCNT_W-1:0]   wait_cnt;
    logic [WCNT_W-1:0]   wait_nxt;
    logic                memstall;
    logic                rs_hit;
    logic                rt_hit;
    logic                loaduse;

    // Hazard detection terms
    assign memstall = mem_req & ~mem_ready;
    assign rs_hit   = use_rs_id & (rs_adr_id == regwrite_adr_ex);
    assign rt_hit   = use_rt_id & (rt_adr_id == regwrite_adr_ex);
    assign loaduse  = memread_ex & regwrite_ex & (rs_hit | rt_hit);

    // Entering the wait from RUN counts as the first stalled cycle
    assign wait_nxt = (state == ST_RUN) ? WCNT_W'(1) : wait_cnt + WCNT_W'(1);

    assign halted = (state == ST_HALT) & ~reset;

    // Same-cycle enables/flushes in priority order
    always_comb begin
        en_pc       = 1'b1;
        en_ifid     = 1'b1;
        en_idex     = 1'b1;
        en_exmem    = 1'b1;
        en_memwb    = 1'b1;
        flush_ifid  = 1'b0;
        flush_idex  = 1'b0;
        flush_exmem = 1'b0;
        flush_memwb = 1'b0;
        if (reset) begin
            en_pc       = 1'b0;
            en_ifid     = 1'b0;
            en_idex     = 1'b0;
            en_exmem    = 1'b0;
            en_memwb    = 1'b0;
            flush_ifid  = 1'b1;
            flush_idex  = 1'b1;
            flush_exmem = 1'b1;
            flush_memwb = 1'b1;
        end else if ((state == ST_HALT) || memstall) begin
            // Front stages frozen; WB receives a bubble so nothing writes back twice
            en_pc       = 1'b0;
            en_ifid     = 1'b0;
            en_idex     = 1'b0;
            en_exmem    = 1'b0;
            flush_memwb = 1'b1;
        end else if (branch_taken_ex) begin
            flush_ifid  = 1'b1;
            flush_idex  = 1'b1;
        end else if (loaduse) begin
            en_pc       = 1'b0;
            en_ifid     = 1'b0;
            flush_idex  = 1'b1;
        end
    end

    // State, wait counter, sticky error and stall statistics
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_RUN;
            wait_cnt  <= '0;
            mem_err   <= 1'b0;
            stall_cnt <= '0;
        end else begin
            if ((state != ST_HALT) && !en_pc && (stall_cnt != CNT_MAX)) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
            case (state)
                ST_RUN, ST_MEMWAIT: begin
                    if (halt_wb) begin
                        state <= ST_HALT;
                    end else if (memstall) begin
                        wait_cnt <= wait_nxt;
                        if (wait_nxt == WAIT_LIMIT) begin
                            state   <= ST_HALT;
                            mem_err <= 1'b1;
                        end else begin
                            state <= ST_MEMWAIT;
                        end
                    end else begin
                        state    <= ST_RUN;
                        wait_cnt <= '0;
                    end
                end
                ST_HALT: begin
                    state <= ST_HALT;
                end
                default: begin
                    state    <= ST_RUN;
                    wait_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed vector table, hand-written corner
// sequences and randomized traffic against a behavioural model.
module tb_pipe_hazard_ctrl;

    localparam int unsigned WAIT_MAX = 4;
    localparam int unsigned CNT_W    = 4;
    localparam int          CNT_SAT  = (1 << CNT_W) - 1;

    // {en_pc,en_ifid,en_idex,en_exmem,en_memwb, flush_ifid,flush_idex,flush_exmem,flush_memwb}
    localparam logic [8:0] C_RST  = 9'b00000_1111;
    localparam logic [8:0] C_RUN  = 9'b11111_0000;
    localparam logic [8:0] C_MEM  = 9'b00001_0001;
    localparam logic [8:0] C_BR   = 9'b11111_1100;
    localparam logic [8:0] C_LU   = 9'b00111_0100;
    localparam logic [8:0] C_HALT = 9'b00001_0001;

    typedef struct packed {
        logic       rst;
        logic       mrd;
        logic       rwr;
        logic [2:0] wadr;
        logic [2:0] rs;
        logic [2:0] rt;
        logic       urs;
        logic       urt;
        logic       br;
        logic       mreq;
        logic       mrdy;
        logic       hlt;
    } stim_t;

    typedef struct packed {
        logic [8:0]       ctrl;
        logic             hl;
        logic             err;
        logic [CNT_W-1:0] cnt;
    } obs_t;

    typedef struct {
        stim_t      s;
        logic [8:0] ctrl;
        logic       hl;
        logic       err;
        int         cnt;
        string      name;
    } vec_t;

    logic             clk = 1'b0;
    logic             reset;
    logic             memread_ex;
    logic             regwrite_ex;
    logic [2:0]       regwrite_adr_ex;
    logic [2:0]       rs_adr_id;
    logic [2:0]       rt_adr_id;
    logic             use_rs_id;
    logic             use_rt_id;
    logic             branch_taken_ex;
    logic             mem_req;
    logic             mem_ready;
    logic             halt_wb;
    logic             en_pc, en_ifid, en_idex, en_exmem, en_memwb;
    logic             flush_ifid, flush_idex, flush_exmem, flush_memwb;
    logic             halted;
    logic             mem_err;
    logic [CNT_W-1:0] stall_cnt;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.WAIT_MAX(WAIT_MAX), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset),
        .memread_ex(memread_ex), .regwrite_ex(regwrite_ex),
        .regwrite_adr_ex(regwrite_adr_ex), .rs_adr_id(rs_adr_id),
        .rt_adr_id(rt_adr_id), .use_rs_id(use_rs_id), .use_rt_id(use_rt_id),
        .branch_taken_ex(branch_taken_ex), .mem_req(mem_req),
        .mem_ready(mem_ready), .halt_wb(halt_wb),
        .en_pc(en_pc), .en_ifid(en_ifid), .en_idex(en_idex),
        .en_exmem(en_exmem), .en_memwb(en_memwb),
        .flush_ifid(flush_ifid), .flush_idex(flush_idex),
        .flush_exmem(flush_exmem), .flush_memwb(flush_memwb),
        .halted(halted), .mem_err(mem_err), .stall_cnt(stall_cnt)
    );

    int checks   = 0;
    int failures = 0;

    // Behavioural model: halt flag, consecutive stalled-cycle streak, error, stall total
    bit m_halted = 1'b0;
    int m_streak = 0;
    bit m_err    = 1'b0;
    int m_stalls = 0;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic stim_t idle();
        stim_t s;
        s = '0;
        return s;
    endfunction

    function automatic stim_t lu(input bit urs, input bit urt, input logic [2:0] rs,
                                 input logic [2:0] rt);
        stim_t s;
        s      = '0;
        s.mrd  = 1'b1;
        s.rwr  = 1'b1;
        s.wadr = 3'd3;
        s.rs   = rs;
        s.rt   = rt;
        s.urs  = urs;
        s.urt  = urt;
        return s;
    endfunction

    function automatic stim_t mstall();
        stim_t s;
        s      = '0;
        s.mreq = 1'b1;
        return s;
    endfunction

    function automatic stim_t rst_s();
        stim_t s;
        s     = '0;
        s.rst = 1'b1;
        return s;
    endfunction

    // Expected control word from the priority rules
    function automatic logic [8:0] exp_ctrl(input stim_t s, input bit in_halt);
        bit hit;
        hit = s.mrd && s.rwr && ((s.urs && s.rs == s.wadr) || (s.urt && s.rt == s.wadr));
        if (s.rst)                return C_RST;
        if (in_halt)              return C_HALT;
        if (s.mreq && !s.mrdy)    return C_MEM;
        if (s.br)                 return C_BR;
        if (hit)                  return C_LU;
        return C_RUN;
    endfunction

    task automatic model_step(input stim_t s, input bit pc_en);
        if (s.rst) begin
            m_halted = 1'b0;
            m_streak = 0;
            m_err    = 1'b0;
            m_stalls = 0;
        end else if (!m_halted) begin
            if (!pc_en && m_stalls < CNT_SAT) m_stalls++;
            if (s.hlt) begin
                m_halted = 1'b1;
            end else if (s.mreq && !s.mrdy) begin
                m_streak++;
                if (m_streak == int'(WAIT_MAX)) begin
                    m_halted = 1'b1;
                    m_err    = 1'b1;
                end
            end else begin
                m_streak = 0;
            end
        end
    endtask

    task automatic drive(input stim_t s);
        reset           = s.rst;
        memread_ex      = s.mrd;
        regwrite_ex     = s.rwr;
        regwrite_adr_ex = s.wadr;
        rs_adr_id       = s.rs;
        rt_adr_id       = s.rt;
        use_rs_id       = s.urs;
        use_rt_id       = s.urt;
        branch_taken_ex = s.br;
        mem_req         = s.mreq;
        mem_ready       = s.mrdy;
        halt_wb         = s.hlt;
    endtask

    // One cycle: drive, sample at negedge against the model, advance at posedge
    task automatic apply(input stim_t s, output obs_t o);
        logic [8:0] e;
        drive(s);
        @(negedge clk);
        e      = exp_ctrl(s, m_halted);
        o.ctrl = {en_pc, en_ifid, en_idex, en_exmem, en_memwb,
                  flush_ifid, flush_idex, flush_exmem, flush_memwb};
        o.hl   = halted;
        o.err  = mem_err;
        o.cnt  = stall_cnt;
        chk("model_ctrl", 32'(o.ctrl), 32'(e));
        chk("model_halted", 32'(o.hl), 32'(m_halted && !s.rst));
        chk("model_mem_err", 32'(o.err), 32'(m_err));
        chk("model_stall_cnt", 32'(o.cnt), 32'(m_stalls));
        @(posedge clk);
        model_step(s, e[8]);
        #1;
    endtask

    task automatic add(input stim_t s, input logic [8:0] c, input logic h, input logic e,
                       input int n, input string name);
        vec_t v;
        v.s = s; v.ctrl = c; v.hl = h; v.err = e; v.cnt = n; v.name = name;
        vecs.push_back(v);
    endtask

    initial begin
        obs_t  o;
        stim_t s;

        // Directed table: outputs sampled in the same cycle as the inputs
        add(rst_s(),                    C_RST,  0, 0, 0, "reset_hold");
        add(idle(),                     C_RUN,  0, 0, 0, "idle_after_reset");
        add(lu(1, 0, 3'd3, 3'd0),       C_LU,   0, 0, 0, "loaduse_rs");
        add(idle(),                     C_RUN,  0, 0, 1, "cnt_after_lu");
        add(lu(0, 1, 3'd3, 3'd5),       C_RUN,  0, 0, 1, "rs_unused_no_stall");
        add(lu(0, 1, 3'd0, 3'd3),       C_LU,   0, 0, 1, "loaduse_rt");
        s = lu(1, 0, 3'd3, 3'd0); s.br = 1'b1;
        add(s,                          C_BR,   0, 0, 2, "branch_over_lu");
        add(idle(),                     C_RUN,  0, 0, 2, "cnt_unchanged_br");
        s = lu(1, 1, 3'd3, 3'd3); s.rwr = 1'b0;
        add(s,                          C_RUN,  0, 0, 2, "no_regwrite_no_stall");
        add(rst_s(),                    C_RST,  0, 0, 2, "reset_mid");
        add(mstall(),                   C_MEM,  0, 0, 0, "memstall_1");
        s = lu(1, 0, 3'd3, 3'd0); s.br = 1'b1; s.mreq = 1'b1;
        add(s,                          C_MEM,  0, 0, 1, "memstall_over_br_lu");
        add(mstall(),                   C_MEM,  0, 0, 2, "memstall_3");
        s = lu(1, 0, 3'd3, 3'd0); s.mreq = 1'b1; s.mrdy = 1'b1;
        add(s,                          C_LU,   0, 0, 3, "ready_normal_prio");
        add(idle(),                     C_RUN,  0, 0, 4, "back_to_run");
        add(mstall(),                   C_MEM,  0, 0, 4, "timeout_1");
        add(mstall(),                   C_MEM,  0, 0, 5, "timeout_2");
        add(mstall(),                   C_MEM,  0, 0, 6, "timeout_3");
        add(mstall(),                   C_MEM,  0, 0, 7, "timeout_4");
        s = lu(1, 0, 3'd3, 3'd0); s.br = 1'b1;
        add(s,                          C_HALT, 1, 1, 8, "halt_after_timeout");
        add(mstall(),                   C_HALT, 1, 1, 8, "halt_ignores_inputs");
        add(rst_s(),                    C_RST,  0, 1, 8, "reset_in_halt");
        add(idle(),                     C_RUN,  0, 0, 0, "run_after_halt_reset");
        s = idle(); s.br = 1'b1; s.hlt = 1'b1;
        add(s,                          C_BR,   0, 0, 0, "halt_wb_with_branch");
        add(idle(),                     C_HALT, 1, 0, 0, "halted_from_halt_wb");
        add(rst_s(),                    C_RST,  0, 0, 0, "reset_clears_halt");
        add(idle(),                     C_RUN,  0, 0, 0, "run_final");

        // First reset cycle: registers are still unknown, so only initialise
        drive(rst_s());
        @(posedge clk);
        model_step(rst_s(), 1'b0);
        #1;

        foreach (vecs[i]) begin
            apply(vecs[i].s, o);
            chk({vecs[i].name, "_ctrl"}, 32'(o.ctrl), 32'(vecs[i].ctrl));
            chk({vecs[i].name, "_halted"}, 32'(o.hl), 32'(vecs[i].hl));
            chk({vecs[i].name, "_mem_err"}, 32'(o.err), 32'(vecs[i].err));
            chk({vecs[i].name, "_stall_cnt"}, 32'(o.cnt), 32'(vecs[i].cnt));
        end

        // Stall counter saturates rather than wrapping
        apply(rst_s(), o);
        for (int i = 0; i < CNT_SAT + 3; i++) apply(lu(1, 0, 3'd3, 3'd0), o);
        apply(idle(), o);
        chk("stall_cnt_saturated", 32'(o.cnt), 32'(CNT_SAT));

        // halt_wb during a memory wait halts without raising mem_err
        apply(rst_s(), o);
        apply(mstall(), o);
        s = mstall(); s.hlt = 1'b1;
        apply(s, o);
        chk("halt_in_wait_ctrl", 32'(o.ctrl), 32'(C_MEM));
        apply(mstall(), o);
        chk("halt_in_wait_halted", 32'(o.hl), 32'(1));
        chk("halt_in_wait_no_err", 32'(o.err), 32'(0));
        chk("halt_in_wait_cnt", 32'(o.cnt), 32'(2));

        // Randomized traffic against the model
        apply(rst_s(), o);
        for (int i = 0; i < 3000; i++) begin
            s      = '0;
            s.rst  = ($urandom_range(0, 59) == 0);
            s.mrd  = $urandom_range(0, 1) == 1;
            s.rwr  = $urandom_range(0, 3) != 0;
            s.wadr = 3'($urandom_range(0, 3));
            s.rs   = 3'($urandom_range(0, 3));
            s.rt   = 3'($urandom_range(0, 3));
            s.urs  = $urandom_range(0, 1) == 1;
            s.urt  = $urandom_range(0, 1) == 1;
            s.br   = $urandom_range(0, 5) == 0;
            s.mreq = $urandom_range(0, 2) == 0;
            s.mrdy = $urandom_range(0, 2) != 0;
            s.hlt  = $urandom_range(0, 79) == 0;
            apply(s, o);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
